// File: rtl/pyramid_addr_gen.sv
// pyramid_addr_gen: walks one downscaled image per round, emitting destination index and nearest-neighbour source address
module pyramid_addr_gen #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int FRAC    = 4,
    parameter int SCALE_W = 13,
    parameter int ADDR_W  = 19,
    parameter int XW      = 10,
    parameter int YW      = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [SCALE_W-1:0] scale,
    input  logic [ADDR_W-1:0]  buf_limit,
    input  logic               bypass,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  addr_request,
    output logic [ADDR_W-1:0]  addr_scale,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic               last,
    output logic               full,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int AW = $clog2((IMG_W + IMG_H + (1 << SCALE_W)) << FRAC) + 1;
    localparam logic [AW-1:0] HALF = AW'(1 << (FRAC - 1));
    localparam logic [SCALE_W-1:0] ONE = SCALE_W'(1 << FRAC);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q;
    logic [SCALE_W-1:0] scale_q;
    logic [AW-1:0] x_acc_q, y_acc_q, x_acc_d, y_acc_d, x_sum, y_sum, nx_d, ny_d;
    logic [ADDR_W-1:0] req_q, addr_q, addr_d;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic wr_en_q, done_q, err_q, wrap, last_d, run, accept;
    assign run = state_q == RUN;
    assign full = run && (req_q >= buf_limit);
    assign out_valid = run && !(full && !bypass);
    assign accept = out_valid && out_ready && !abort;
    assign last = run && last_d;
    assign busy = state_q != IDLE;
    assign wr_en = wr_en_q;
    assign done = done_q;
    assign err = err_q;
    assign addr_request = req_q;
    assign addr_scale = addr_q;
    assign x = x_q;
    assign y = y_q;
    // Next source position: step the column, wrap to the next source row once the rounded column leaves the image
    always_comb begin
        x_sum = x_acc_q + AW'(scale_q);
        y_sum = y_acc_q + AW'(scale_q);
        wrap = ((x_sum + HALF) >> FRAC) >= AW'(IMG_W);
        x_acc_d = wrap ? '0 : x_sum;
        y_acc_d = wrap ? y_sum : y_acc_q;
        nx_d = (x_acc_d + HALF) >> FRAC;
        ny_d = (y_acc_d + HALF) >> FRAC;
        addr_d = ADDR_W'(ny_d) * ADDR_W'(IMG_W) + ADDR_W'(nx_d);
        last_d = wrap && (((y_sum + HALF) >> FRAC) >= AW'(IMG_H));
    end
    // Round control FSM and registered beat outputs; abort overrides start and acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            scale_q <= '0;
            x_acc_q <= '0;
            y_acc_q <= '0;
            req_q   <= '0;
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wr_en_q <= accept;
            done_q  <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                x_acc_q <= '0;
                y_acc_q <= '0;
                req_q   <= '0;
                addr_q  <= '0;
                x_q     <= '0;
                y_q     <= '0;
            end else begin
                case (state_q)
                    IDLE: if (start) begin
                        if (scale >= ONE) begin
                            state_q <= RUN;
                            scale_q <= scale;
                            err_q   <= 1'b0;
                            x_acc_q <= '0;
                            y_acc_q <= '0;
                            req_q   <= '0;
                            addr_q  <= '0;
                            x_q     <= '0;
                            y_q     <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    RUN: if (accept) begin
                        if (last_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            x_acc_q <= x_acc_d;
                            y_acc_q <= y_acc_d;
                            req_q   <= req_q + 1'b1;
                            addr_q  <= addr_d;
                            x_q     <= XW'(nx_d);
                            y_q     <= YW'(ny_d);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pyramid_addr_gen.sv
// tb_pyramid_addr_gen: scoreboard bench for pyramid_addr_gen on a reduced 20x12 image
module tb_pyramid_addr_gen;
    localparam int W = 20;
    localparam int H = 12;
    typedef struct packed {
        logic [18:0] req;
        logic [18:0] addr;
        logic [9:0]  x;
        logic [8:0]  y;
        logic        last;
    } beat_t;
    logic clk = 1'b0;
    logic rst_n, start, abort, bypass, out_ready;
    logic [12:0] scale;
    logic [18:0] buf_limit;
    logic out_valid, wr_en, last, full, busy, done, err;
    logic [18:0] addr_request, addr_scale;
    logic [9:0] x;
    logic [8:0] y;
    beat_t q[$];
    beat_t hold_vec;
    logic hold_v = 1'b0, prev_acc = 1'b0, prev_last_acc = 1'b0;
    logic [18:0] last_req = '0;
    int n_tests = 0, n_fail = 0, n_acc = 0, done_cnt = 0, d0 = 0;

    pyramid_addr_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .scale(scale),
        .buf_limit(buf_limit), .bypass(bypass), .out_valid(out_valid), .out_ready(out_ready),
        .wr_en(wr_en), .addr_request(addr_request), .addr_scale(addr_scale), .x(x), .y(y),
        .last(last), .full(full), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] outs();
        return {out_valid, wr_en, addr_request, addr_scale, x, y, last, full, busy, done, err};
    endfunction

    function automatic beat_t cur();
        return {addr_request, addr_scale, x, y, last};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_model(input int sc);
        beat_t e;
        int idx = 0;
        for (int r = 0; ((r * sc + 8) >> 4) < H; r++) begin
            for (int c = 0; ((c * sc + 8) >> 4) < W; c++) begin
                int sx = (c * sc + 8) >> 4;
                int sy = (r * sc + 8) >> 4;
                e.req = 19'(idx);
                e.addr = 19'(sy * W + sx);
                e.x = 10'(sx);
                e.y = 9'(sy);
                e.last = 1'b0;
                q.push_back(e);
                idx++;
            end
        end
        e = q.pop_back();
        e.last = 1'b1;
        q.push_back(e);
    endtask

    task automatic step();
        logic acc;
        beat_t e, o;
        @(negedge clk);
        acc = out_valid && out_ready && !abort;
        chk("wr_en", wr_en, rst_n ? prev_acc : 1'b0);
        if (hold_v && out_valid) chk("stall_hold", cur(), hold_vec);
        hold_v = out_valid && !out_ready && !abort;
        hold_vec = cur();
        if (done) begin
            done_cnt++;
            chk("done_after_last", prev_last_acc, 1'b1);
            chk("done_valid", out_valid, 1'b0);
        end
        if (acc) begin
            n_acc++;
            n_tests++;
            assert (q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_underflow: observed req=%0d with expected queue empty", addr_request);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                o = cur();
                last_req = e.req;
                n_tests++;
                assert (o === e) else begin
                    n_fail++;
                    $error("FAIL beat: observed req=%0d addr=%0d x=%0d y=%0d last=%0b expected req=%0d addr=%0d x=%0d y=%0d last=%0b",
                           o.req, o.addr, o.x, o.y, o.last, e.req, e.addr, e.x, e.y, e.last);
                end
            end
        end
        prev_acc = acc;
        prev_last_acc = acc && last;
        @(posedge clk);
        #1;
    endtask

    task automatic run_start(input int sc);
        push_model(sc);
        scale = 13'(sc);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("first_valid", out_valid, 1'b1);
        chk("busy_run", busy, 1'b1);
        chk("err_clear", err, 1'b0);
    endtask

    task automatic wait_done(input bit rnd);
        int k = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && k < 4000) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        out_ready = 1'b1;
        chk("done_seen", 64'(done_cnt), 64'(d0 + 1));
        step();
        chk("idle_after_done", busy, 1'b0);
        chk("hold_req", addr_request, last_req);
        chk("sb_empty", 64'(q.size()), 64'(0));
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; scale = '0;
        buf_limit = '1; bypass = 1'b1; out_ready = 1'b1;
        #1 rst_n = 1'b0;
        step();
        step();
        chk("reset_outs", outs(), 64'(0));
        rst_n = 1'b1;
        step();
        run_start(16);
        wait_done(1'b0);
        run_start(32);
        wait_done(1'b0);
        run_start(23);
        wait_done(1'b0);
        chk("end_req_s23", addr_request, 19'(111));
        bypass = 1'b0;
        buf_limit = 19'(30);
        n_acc = 0;
        run_start(16);
        repeat (40) step();
        chk("credit_beats", 64'(n_acc), 64'(30));
        chk("credit_full", full, 1'b1);
        chk("credit_valid", out_valid, 1'b0);
        chk("credit_req", addr_request, 19'(30));
        bypass = 1'b1;
        wait_done(1'b0);
        chk("credit_total", 64'(n_acc), 64'(240));
        n_acc = 0;
        run_start(23);
        wait_done(1'b1);
        chk("rand_total", 64'(n_acc), 64'(112));
        scale = 13'(15);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("err_set", err, 1'b1);
        chk("err_busy", busy, 1'b0);
        step();
        chk("err_idle_valid", out_valid, 1'b0);
        run_start(16);
        wait_done(1'b0);
        run_start(16);
        repeat (25) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_outs", outs(), 64'(0));
        q.delete();
        d0 = done_cnt;
        repeat (5) step();
        chk("abort_no_done", 64'(done_cnt), 64'(d0));
        run_start(16);
        repeat (25) step();
        rst_n = 1'b0;
        #1;
        chk("rst_outs", outs(), 64'(0));
        step();
        rst_n = 1'b1;
        q.delete();
        d0 = done_cnt;
        repeat (5) step();
        chk("rst_no_done", 64'(done_cnt), 64'(d0));
        chk("rst_idle", busy, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
